vr_arbiter: RTL
===============

# vr_arbiter

Round-robin arbiter sharing one valid/ready sink, such as the `destination` capture buffer, between up to `NUM_SRC` valid/ready sources. It grants one source at a time and forwards that source's valid/data to the sink and the sink's ready back to it. A grant is held for a bounded burst so one source cannot starve the others. It sits between the source interfaces and the single downstream destination port.

## Interface
- `NUM_SRC`, 4: number of requesting sources, ≥2.
- `WIDTH`, 8: data width per beat.
- `BURST_LEN`, 16: maximum beats per grant before forced re-arbitration, ≥1.
- `clk` input 1: single clock, rising edge.
- `s_rst` input 1: reset, asynchronous, active-high.
- `s_valid` input `NUM_SRC`: per-source valid.
- `s_data` input `NUM_SRC*WIDTH`: source i at `[i*WIDTH +: WIDTH]`.
- `s_ready` output `NUM_SRC`: per-source ready, one-hot or zero.
- `m_valid` output 1: valid to the destination.
- `m_data` output `WIDTH`: data to the destination.
- `m_ready` input 1: ready from the destination.
- `grant_id` output `$clog2(NUM_SRC)`: index of the current grant.
- `busy` output 1: high while in GRANT.

## Operation
- A beat transfers on source i when `s_valid[i] & s_ready[i]`. Downstream, a beat transfers when `m_valid & m_ready`.
- Sources must hold valid and data stable until their beat transfers. The sink may wait for valid before raising ready.
- FSM states:
  - IDLE: no grant. If any `s_valid` bit is set, pick a winner round-robin, register `grant_id`, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: pass-through of the granted source.
- Outputs in GRANT (registered `grant_id` = g):
  - `m_valid = s_valid[g]`
  - `m_data = s_data[g]`
  - `s_ready[g] = m_ready`
  - all other `s_ready` bits 0.
- Outputs in IDLE: `m_valid=0`, `m_data=0`, `s_ready=0`.
- Round-robin order: search starts at `last_grant+1` modulo `NUM_SRC` and wraps. After reset `last_grant = NUM_SRC-1`, so source 0 has highest priority first.
- Beat counter (width `$clog2(BURST_LEN+1)`): cleared on entry to GRANT, incremented on each transfer.
- GRANT → IDLE when either of these holds:
  - a transfer occurs with count = `BURST_LEN-1`, i.e. the burst is complete;
  - `s_valid[g]` is 0 in a GRANT cycle, i.e. the source is idle.
- On release, `last_grant` ← g.
- While `s_valid[g]` is high and `m_ready` is low, GRANT holds indefinitely. There is no timeout.

## Timing
- Reset values: state IDLE, `grant_id=0`, `last_grant=NUM_SRC-1`, count 0, `busy=0`. All combinational outputs (`m_valid`, `m_data`, `s_ready`) are 0 while `s_rst` is high.
- Request to first `m_valid`: 1 cycle (the IDLE arbitration cycle, then GRANT).
- Ready path is combinational (`m_ready` → `s_ready[g]`). Valid and data paths are combinational mux outputs selected by the registered grant.
- Every release costs exactly one IDLE bubble cycle before the next grant.
- Reset mid-burst: state and grant clear immediately and asynchronously. An in-flight beat that has not handshaken is dropped, and no transfer is reported for it. First arbitration happens on the first clock edge after `s_rst` falls.
- Requests arriving during GRANT wait for release. They are never preempted except by burst completion.

## Structure
- Package `vr_arb_pkg` holds:
  - state enum (IDLE=1'b0, GRANT=1'b1);
  - `NUM_SRC`/`WIDTH`/`BURST_LEN` defaults;
  - localparams for id and count widths.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, `last_grant`.
  - Outputs: winner index, `any_req`.
- The top holds the FSM, counter, grant registers and output mux.

## Test plan
- Single source 2 streams 3 beats (`0xA1`, `0xA2`, `0xA3`), sink always ready → `m_data` sequence A1, A2, A3. `grant_id=2`. First `m_valid` 1 cycle after `s_valid[2]`. Release after valid drops.
- Sources 0–3 all requesting continuously with `BURST_LEN=4` → grants in order 0,1,2,3,0, exactly 4 beats each, one idle bubble between grants.
- Sink stalls `m_ready=0` for 10 cycles mid-burst → `m_valid` and `m_data` held stable, `s_ready=0`, no beat lost or duplicated, count unchanged.
- Source 1 holds after 2 of 16 beats while source 3 requests → release, one IDLE cycle, then `grant_id=3`.
- Assert `s_rst` mid-burst between clock edges → `m_valid`, `s_ready`, `busy` drop immediately. After release, source 0 wins first when all request.
- `NUM_SRC=2` wrap check: alternating requests → grants 0,1,0,1. No source starved over 100 bursts.

Source files
------------

// File: rtl/vr_arb_pkg.sv
// Shared types and defaults for the valid/ready round-robin arbiter.
// Holds the FSM state encoding, default parameter values and derived widths.
// Imported by vr_arbiter and rr_pick.
package vr_arb_pkg;

  // Default configuration.
  localparam int DEF_NUM_SRC   = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_BURST_LEN = 16;

  // Width of a source index and of the per-grant beat counter.
  localparam int DEF_ID_W  = $clog2(DEF_NUM_SRC);
  localparam int DEF_CNT_W = $clog2(DEF_BURST_LEN + 1);

  // Arbiter FSM: no grant / one source passed through to the sink.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for n sources; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
// Ports: req (per-source request), last_grant (previous winner),
//        winner (chosen index, 0 when nothing requests), any_req (OR of req).
module rr_pick
  import vr_arb_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ID_W    = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic found;
  logic req_bit;
  int   idx;

  // Walk offsets 1..NUM_SRC from the previous winner; the first set bit wins.
  // Offset NUM_SRC lands back on last_grant itself, so a lone requester that
  // just finished can still be re-granted.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    req_bit = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx     = (int'(last_grant) + k) % NUM_SRC;
      req_bit = |(req & (NUM_SRC'(1) << idx));
      if (!found && req_bit) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/vr_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink between NUM_SRC sources,
// holding each grant for at most BURST_LEN beats, with one IDLE bubble per release.
// Ports: clk, s_rst (async, active-high); s_valid/s_data/s_ready per source;
//        m_valid/m_data/m_ready to the sink; grant_id (current grant), busy (in GRANT).
module vr_arbiter
  import vr_arb_pkg::*;
#(
  parameter  int NUM_SRC   = DEF_NUM_SRC,
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int BURST_LEN = DEF_BURST_LEN,
  localparam int ID_W      = id_width(NUM_SRC),
  localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     s_rst,
  input  logic [NUM_SRC-1:0]       s_valid,
  input  logic [NUM_SRC*WIDTH-1:0] s_data,
  output logic [NUM_SRC-1:0]       s_ready,
  output logic                     m_valid,
  output logic [WIDTH-1:0]         m_data,
  input  logic                     m_ready,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  LAST_SRC  = ID_W'(NUM_SRC - 1);

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  grant_nxt;
  logic [ID_W-1:0]  last_grant, last_grant_nxt;
  logic [CNT_W-1:0] count, count_nxt;

  logic [ID_W-1:0]  pick_id;
  logic             pick_any;

  logic             g_valid;
  logic             xfer;
  logic             burst_done;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (s_valid),
    .last_grant (last_grant),
    .winner     (pick_id),
    .any_req    (pick_any)
  );

  // Granted source's valid and the handshake it makes with the sink.
  assign g_valid    = s_valid[grant_id];
  assign xfer       = (state == GRANT) && g_valid && m_ready;
  assign burst_done = xfer && (count == LAST_BEAT);

  always_ff @(posedge clk or posedge s_rst) begin
    if (s_rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= LAST_SRC;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_grant_nxt;
      count      <= count_nxt;
    end
  end

  // Next-state logic. grant_id only changes on arbitration, so in IDLE it
  // still shows the most recent winner.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    count_nxt      = count;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          grant_nxt = pick_id;
          count_nxt = '0;
        end
      end
      GRANT: begin
        // A source that drops valid gives up the grant at once; otherwise it
        // keeps it until its burst is spent, however long the sink stalls.
        if (!g_valid || burst_done) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant_id;
          count_nxt      = '0;
        end else if (xfer) begin
          count_nxt = count + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pass-through mux. Gated by s_rst as well so the outputs fall in the same
  // instant reset rises, independent of the register clear.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    s_ready = '0;
    if ((state == GRANT) && !s_rst) begin
      m_valid           = g_valid;
      m_data            = WIDTH'(s_data >> (int'(grant_id) * WIDTH));
      s_ready[grant_id] = m_ready;
    end
  end

  assign busy = (state == GRANT);

  // At most one source is ever offered ready, and only while granted.
  a_ready_onehot : assert property (@(posedge clk) disable iff (s_rst)
    $onehot0(s_ready));
  a_valid_in_grant : assert property (@(posedge clk) disable iff (s_rst)
    m_valid |-> (state == GRANT));

endmodule
